fetch_mem_arbiter: RTL

- Shares one instruction memory port (request/dataOk handshake, testRom-compatible) between the way0 and way1 fetch units of the dual-way core.
- Round-robin arbitration; one outstanding memory transaction at a time.
- Jump flush drops in-flight responses.
- Timeout watchdog flags a memory port that never answers.

---
 rtl/fetch_arb_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 32 +++
 rtl/fetch_mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_arb_pkg
// Brief   : Shared types and defaults for the fetch memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_arb_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        WAY0 = 1'b0,
        WAY1 = 1'b1
    } owner_t;

    // Watchdog counter width; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-input round-robin grant; pointer moves to the loser on update.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_gnt
);

    logic r_ptr;

    always_comb begin
        o_valid = |i_req;
        o_gnt   = (i_req == 2'b11) ? r_ptr : i_req[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_update && o_valid) begin
            r_ptr <= ~o_gnt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fetch_mem_arbiter
// Brief   : Shares one instruction memory port between two fetch ways.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_mem_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              way0_request_i,
    input  logic [ADDR_W-1:0] way0_instAddr_i,
    output logic [DATA_W-1:0] way0_inst_o,
    output logic              way0_dataOk_o,
    input  logic              way1_request_i,
    input  logic [ADDR_W-1:0] way1_instAddr_i,
    output logic [DATA_W-1:0] way1_inst_o,
    output logic              way1_dataOk_o,
    input  logic              flush_i,
    output logic              mem_request_o,
    output logic [ADDR_W-1:0] mem_instAddr_o,
    input  logic [DATA_W-1:0] mem_inst_i,
    input  logic              mem_dataOk_i,
    output logic              timeout_err_o
);

    localparam int                 CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_owner;
    logic              r_drop;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_inst0;
    logic [DATA_W-1:0] r_inst1;
    logic              r_ok0;
    logic              r_ok1;
    logic              r_timeout;

    logic              w_arb_valid;
    logic              w_arb_gnt;
    logic              w_grant;
    logic              w_resp;
    logic              w_deliver;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({way1_request_i, way0_request_i}),
        .i_update (w_grant),
        .o_valid  (w_arb_valid),
        .o_gnt    (w_arb_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_resp      = 1'b0;
        w_deliver   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_dataOk_i) begin
                    w_resp      = 1'b1;
                    // A flush landing with the data kills it just like an earlier one.
                    w_deliver   = !r_drop && !flush_i;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= WAY0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_inst0    <= '0;
            r_inst1    <= '0;
            r_ok0      <= 1'b0;
            r_ok1      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_ok0 <= 1'b0;
            r_ok1 <= 1'b0;
            if (w_grant) begin
                r_owner    <= owner_t'(w_arb_gnt);
                r_mem_addr <= w_arb_gnt ? way1_instAddr_i : way0_instAddr_i;
                r_mem_req  <= 1'b1;
                r_cnt      <= '0;
                r_drop     <= 1'b0;
            end
            if (r_state == BUSY) begin
                if (w_resp) begin
                    r_mem_req <= 1'b0;
                    r_drop    <= 1'b0;
                end else if (flush_i) begin
                    r_drop <= 1'b1;
                end
                // Saturating watchdog; the error is sticky and does not abort.
                if (r_cnt == c_CNT_LAST) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_deliver) begin
                if (r_owner == WAY1) begin
                    r_inst1 <= mem_inst_i;
                    r_ok1   <= 1'b1;
                end else begin
                    r_inst0 <= mem_inst_i;
                    r_ok0   <= 1'b1;
                end
            end
        end
    end

    assign way0_inst_o    = r_inst0;
    assign way0_dataOk_o  = r_ok0;
    assign way1_inst_o    = r_inst1;
    assign way1_dataOk_o  = r_ok1;
    assign mem_request_o  = r_mem_req;
    assign mem_instAddr_o = r_mem_addr;
    assign timeout_err_o  = r_timeout;

endmodule
`default_nettype wire
